// File: rtl/rect_pkg.sv
// rect_pkg: mode/state encodings and screen defaults for the rectangle rasteriser
package rect_pkg;
   localparam logic [1:0] MODE_FILL    = 2'b00;
   localparam logic [1:0] MODE_OUTLINE = 2'b01;
   localparam logic [1:0] MODE_ERASE   = 2'b10;
   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SCAN, ST_DONE} state_t;
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major cx/cy walker; outline mode skips the inside of interior rows
module rect_scan_counter #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           en,
   input  logic           clear,
   input  logic           skip_interior,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   output logic [X_W-1:0] cx,
   output logic [Y_W-1:0] cy,
   output logic           last
);
   logic row_end, interior;
   assign row_end  = cx == w - X_W'(1);
   assign interior = skip_interior && cy != '0 && cy != h - Y_W'(1);
   assign last     = row_end && cy == h - Y_W'(1);
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cx <= '0;
         cy <= '0;
      end else if (clear) begin
         cx <= '0;
         cy <= '0;
      end else if (en) begin
         cx <= row_end ? '0 : (interior && cx == '0) ? w - X_W'(1) : cx + X_W'(1);
         cy <= row_end ? cy + Y_W'(1) : cy;
      end
endmodule

// File: rtl/rect_raster.sv
// rect_raster: one-pixel-per-clock rectangle fill/outline/erase with screen clipping and abort
module rect_raster import rect_pkg::*; #(
   parameter int                 X_W      = 8,
   parameter int                 Y_W      = 7,
   parameter int                 COLOR_W  = 3,
   parameter int                 SCREEN_W = SCREEN_W_DEF,
   parameter int                 SCREEN_H = SCREEN_H_DEF,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   input  logic [X_W-1:0]     x0,
   input  logic [Y_W-1:0]     y0,
   input  logic [X_W-1:0]     w,
   input  logic [Y_W-1:0]     h,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] color_in,
   output logic               busy,
   output logic               done,
   output logic               plot,
   output logic [X_W-1:0]     x_out,
   output logic [Y_W-1:0]     y_out,
   output logic [COLOR_W-1:0] color_out
);
   state_t             state;
   logic [X_W-1:0]     x0_q, w_q, cx;
   logic [Y_W-1:0]     y0_q, h_q, cy;
   logic [COLOR_W-1:0] color_q;
   logic               outline_q, last, accept, scanning;
   logic [X_W:0]       xs;
   logic [Y_W:0]       ys;
   assign accept    = state == ST_IDLE && start;
   assign scanning  = state == ST_SCAN && !abort;
   // one extra bit so coordinates past the port width still clip instead of wrapping on-screen
   assign xs        = {1'b0, x0_q} + {1'b0, cx};
   assign ys        = {1'b0, y0_q} + {1'b0, cy};
   assign x_out     = xs[X_W-1:0];
   assign y_out     = ys[Y_W-1:0];
   assign color_out = color_q;
   assign plot      = scanning && xs < (X_W+1)'(SCREEN_W) && ys < (Y_W+1)'(SCREEN_H);
   assign busy      = state != ST_IDLE;
   assign done      = state == ST_DONE;
   rect_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
      .clk          (clk),
      .resetn       (resetn),
      .en           (scanning),
      .clear        (accept),
      .skip_interior(outline_q),
      .w            (w_q),
      .h            (h_q),
      .cx           (cx),
      .cy           (cy),
      .last         (last)
   );
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state     <= ST_IDLE;
         x0_q      <= '0;
         y0_q      <= '0;
         w_q       <= '0;
         h_q       <= '0;
         color_q   <= '0;
         outline_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (start) begin
                  x0_q      <= x0;
                  y0_q      <= y0;
                  w_q       <= w;
                  h_q       <= h;
                  outline_q <= mode == MODE_OUTLINE;
                  color_q   <= mode == MODE_ERASE ? BG_COLOR : color_in;
                  state     <= ST_SETUP;
               end
            ST_SETUP: state <= abort ? ST_IDLE : (w_q == '0 || h_q == '0) ? ST_DONE : ST_SCAN;
            ST_SCAN:  state <= abort ? ST_IDLE : last ? ST_DONE : ST_SCAN;
            default:  state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_rect_raster.sv
// tb_rect_raster: cycle-exact check of rect_raster against a pixel-list reference model
module tb_rect_raster;
   import rect_pkg::*;
   logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
   logic [7:0] x0 = '0, w = '0;
   logic [6:0] y0 = '0, h = '0;
   logic [1:0] mode = '0;
   logic [2:0] color_in = '0;
   logic       busy, done, plot;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;
   int n_checks = 0, n_err = 0;
   always #5 clk = ~clk;
   rect_raster dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .abort    (abort),
      .x0       (x0),
      .y0       (y0),
      .w        (w),
      .h        (h),
      .mode     (mode),
      .color_in (color_in),
      .busy     (busy),
      .done     (done),
      .plot     (plot),
      .x_out    (x_out),
      .y_out    (y_out),
      .color_out(color_out)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic scramble();
      x0       = 8'($urandom);
      y0       = 7'($urandom);
      w        = 8'($urandom);
      h        = 7'($urandom);
      mode     = 2'($urandom);
      color_in = 3'($urandom);
      start    = 1'($urandom);
   endtask
   // abort_at: scan index to abort in, -2 aborts in SETUP, anything unreachable means no abort
   task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                          input logic [1:0] am, input logic [2:0] ac, input int abort_at, input bit noise);
      int ex[$];
      int ey[$];
      bit ep[$];
      logic [2:0] ecol;
      for (int r = 0; r < ah; r++)
         for (int c = 0; c < aw; c++) begin
            if (am == MODE_OUTLINE && r != 0 && r != ah - 1 && c != 0 && c != aw - 1) continue;
            ex.push_back((ax0 + c) % 256);
            ey.push_back((ay0 + r) % 128);
            ep.push_back(ax0 + c < 160 && ay0 + r < 120);
         end
      ecol = am == MODE_ERASE ? 3'b000 : ac;
      x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah); mode = am; color_in = ac;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("setup_busy", 32'(busy), 32'(1));
      check("setup_plot", 32'(plot), 32'(0));
      check("setup_done", 32'(done), 32'(0));
      if (abort_at == -2) begin
         abort = 1'b1;
         #1 check("abort_setup_plot", 32'(plot), 32'(0));
         @(negedge clk);
         abort = 1'b0;
         check("abort_setup_busy", 32'(busy), 32'(0));
         check("abort_setup_done", 32'(done), 32'(0));
         return;
      end
      if (noise) scramble();
      for (int i = 0; i < ex.size(); i++) begin
         @(negedge clk);
         if (i == abort_at) begin
            abort = 1'b1;
            #1 check("abort_plot", 32'(plot), 32'(0));
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            check("abort_busy", 32'(busy), 32'(0));
            check("abort_done", 32'(done), 32'(0));
            return;
         end
         check("plot", 32'(plot), 32'(ep[i]));
         check("x", 32'(x_out), 32'(ex[i]));
         check("y", 32'(y_out), 32'(ey[i]));
         if (ep[i]) check("color", 32'(color_out), 32'(ecol));
         check("scan_busy", 32'(busy), 32'(1));
         check("scan_done", 32'(done), 32'(0));
         if (noise) scramble();
      end
      @(negedge clk);
      check("done", 32'(done), 32'(1));
      check("done_busy", 32'(busy), 32'(1));
      check("done_plot", 32'(plot), 32'(0));
      start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("post_done", 32'(done), 32'(0));
      check("post_busy", 32'(busy), 32'(0));
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_plot", 32'(plot), 32'(0));
      check("rst_x", 32'(x_out), 32'(0));
      check("rst_y", 32'(y_out), 32'(0));
      check("rst_color", 32'(color_out), 32'(0));
      resetn = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'(0));
      run_cmd(74, 10, 13, 1, MODE_FILL, 3'b010, -1, 1'b0);
      run_cmd(50, 10, 4, 3, MODE_OUTLINE, 3'b101, -1, 1'b0);
      run_cmd(158, 118, 4, 3, MODE_FILL, 3'b011, -1, 1'b1);
      run_cmd(30, 30, 0, 5, MODE_FILL, 3'b001, -1, 1'b0);
      run_cmd(30, 30, 6, 0, MODE_OUTLINE, 3'b001, -1, 1'b0);
      run_cmd(20, 30, 10, 4, MODE_ERASE, 3'b111, 2, 1'b0);
      run_cmd(20, 30, 10, 4, MODE_ERASE, 3'b111, -1, 1'b0);
      run_cmd(5, 5, 3, 3, 2'b11, 3'b110, -2, 1'b0);
      run_cmd(7, 9, 1, 5, MODE_OUTLINE, 3'b100, -1, 1'b0);
      run_cmd(200, 5, 255, 3, MODE_FILL, 3'b010, -1, 1'b1);
      // asynchronous reset in the middle of a scan
      x0 = 8'd10; y0 = 7'd20; w = 8'd30; h = 7'd5; mode = MODE_FILL; color_in = 3'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_plot", 32'(plot), 32'(1));
      check("pre_rst_x", 32'(x_out), 32'(13));
      #2 resetn = 1'b0;
      #1;
      check("arst_plot", 32'(plot), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_done", 32'(done), 32'(0));
      check("arst_x", 32'(x_out), 32'(0));
      check("arst_y", 32'(y_out), 32'(0));
      check("arst_color", 32'(color_out), 32'(0));
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'(0));
      check("post_rst_done", 32'(done), 32'(0));
      for (int n = 0; n < 40; n++) begin
         int ax0, ay0;
         ax0 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 255));
         ay0 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(105, 127)) : int'($urandom_range(0, 127));
         run_cmd(ax0, ay0, int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
                 2'($urandom), 3'($urandom),
                 ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 3) == 0) ? -2 : int'($urandom_range(0, 30))) : -1,
                 1'($urandom));
      end
      run_cmd(0, 0, 255, 127, MODE_OUTLINE, 3'b111, -1, 1'b1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
